// File: rtl/net_tx_arbiter_pkg.sv
// Shared definitions for the network transmit arbiter: FSM states, the
// filler byte used for aborted frames, source slot numbering and the
// modular index helper used by the round-robin selector.
package net_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_ABORT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_e;

  // Byte emitted on the single terminating beat of an aborted frame.
  localparam logic [7:0] NET_ABORT_FILL = 8'h00;

  // Source slot numbering used by the network top level.
  localparam int SRC_ARP_REPLY = 0;
  localparam int SRC_ARP_QUERY = 1;
  localparam int SRC_UDP       = 2;

  // (base + off) mod n for base, off < n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/net_tx_arbiter_rr_pick.sv
// Rotate-priority selector: returns the first asserted request found when
// searching upward from the pointer with wrap-around, as one-hot and index.
module rr_pick
  import net_tx_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_in,
  input  logic [PTR_W-1:0] ptr_in,
  output logic [N-1:0]     onehot_out,
  output logic [PTR_W-1:0] idx_out,
  output logic             any_out
);

  // Scan from farthest to nearest so the request closest to the pointer wins.
  always_comb begin
    onehot_out = '0;
    idx_out    = '0;
    any_out    = |req_in;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_in[rr_wrap(int'(ptr_in), k, N)]) begin
        onehot_out = '0;
        onehot_out[rr_wrap(int'(ptr_in), k, N)] = 1'b1;
        idx_out = PTR_W'(rr_wrap(int'(ptr_in), k, N));
      end
    end
  end

endmodule

// File: rtl/net_tx_arbiter.sv
// Frame-granular round-robin arbiter for the 8-bit network transmit stream.
// The grant is held for a whole frame, an idle gap follows every frame, and
// a source that stalls mid-frame for too long has its frame terminated with
// a filler beat while the rest of its frame is drained and discarded.
//
// Handshake: a beat moves on any stream when valid & ready are both high at
// the rising clock edge; valid never depends on ready, data/last are only
// meaningful while valid is high.
module net_tx_arbiter
  import net_tx_arbiter_pkg::*;
#(
  parameter int N_SRC          = 3,
  parameter int IFG_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic               logic_clk,
  input  logic               logic_rst,
  input  logic [8*N_SRC-1:0] src_tdata_in,
  input  logic [N_SRC-1:0]   src_tvalid_in,
  output logic [N_SRC-1:0]   src_tready_out,
  input  logic [N_SRC-1:0]   src_tlast_in,
  output logic [7:0]         net_tdata_out,
  output logic               net_tvalid_out,
  input  logic               net_tready_in,
  output logic               net_tlast_out,
  output logic [N_SRC-1:0]   grant_out,
  output logic               busy_out,
  output logic               abort_out
);

  localparam int PTR_W = (N_SRC > 2) ? 2 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = (IFG_CYCLES > 0) ? CNT_W'(IFG_CYCLES - 1) : '0;

  arb_state_e         state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;

  logic [N_SRC-1:0]   pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               g_valid, g_last;
  logic [7:0]         g_data;
  logic [PTR_W-1:0]   ptr_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               frame_done;

  rr_pick #(
    .N     (N_SRC),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_in     (src_tvalid_in),
    .ptr_in     (ptr_q),
    .onehot_out (pick_onehot),
    .idx_out    (pick_idx),
    .any_out    (pick_any)
  );

  // Signals of the currently granted source.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = 8'h00;
    for (int i = 0; i < N_SRC; i++) begin
      if (gidx_q == PTR_W'(i)) begin
        g_valid = src_tvalid_in[i];
        g_last  = src_tlast_in[i];
        g_data  = src_tdata_in[8*i +: 8];
      end
    end
  end

  // Next-state logic: arbitration, frame tracking, stall timeout and gap.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    abort_d    = 1'b0;
    frame_done = 1'b0;
    ptr_next   = (gidx_q == PTR_W'(N_SRC - 1)) ? '0 : gidx_q + 1'b1;
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        if (g_valid && net_tready_in && g_last) begin
          // A completed frame always wins over a timeout.
          frame_done = 1'b1;
        end else if (g_valid) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TO_VAL)) begin
            state_d = ST_ABORT;
            abort_d = 1'b1;
          end
        end
      end
      ST_ABORT: begin
        if (net_tready_in) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        // Source is held ready; its remaining beats are swallowed here.
        if (g_valid && g_last) frame_done = 1'b1;
      end
      ST_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase

    if (frame_done) begin
      ptr_d   = ptr_next;
      grant_d = '0;
      cnt_d   = '0;
      state_d = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PTR_W'(SRC_ARP_REPLY);
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // Stream steering; everything idles outside FWD/ABORT/DRAIN.
  always_comb begin
    net_tvalid_out = 1'b0;
    net_tdata_out  = 8'h00;
    net_tlast_out  = 1'b0;
    src_tready_out = '0;
    case (state_q)
      ST_FWD: begin
        net_tvalid_out = g_valid;
        net_tdata_out  = g_valid ? g_data : 8'h00;
        net_tlast_out  = g_last;
        src_tready_out = grant_q & {N_SRC{net_tready_in}};
      end
      ST_ABORT: begin
        net_tvalid_out = 1'b1;
        net_tdata_out  = NET_ABORT_FILL;
        net_tlast_out  = 1'b1;
      end
      ST_DRAIN: begin
        src_tready_out = grant_q;
      end
      default: begin
        net_tvalid_out = 1'b0;
      end
    endcase
  end

  assign grant_out = grant_q;
  assign busy_out  = (state_q != ST_IDLE);
  assign abort_out = abort_q;

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Bench for net_tx_arbiter: per-cycle vector tables for single-source,
// backpressure, timeout/drain and pre-reset traffic, a small source model
// with an expected-beat queue for the fairness run, and a mid-frame reset.
module tb_net_tx_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic [23:0] src_tdata;
  logic [2:0]  src_tvalid, src_tready, src_tlast;
  logic [7:0]  net_tdata;
  logic        net_tvalid, net_tready, net_tlast;
  logic [2:0]  grant;
  logic        busy, abort_o;

  // Table-driven inputs and source-model inputs, selected by model_en.
  logic [2:0]  tbl_v, tbl_l;
  logic [23:0] tbl_d;
  logic        tbl_rdy;
  logic [2:0]  mdl_v, mdl_l;
  logic [23:0] mdl_d;
  logic        model_en;
  logic        mon_en;

  assign src_tvalid = model_en ? mdl_v : tbl_v;
  assign src_tlast  = model_en ? mdl_l : tbl_l;
  assign src_tdata  = model_en ? mdl_d : tbl_d;
  assign net_tready = model_en ? 1'b1  : tbl_rdy;

  net_tx_arbiter #(
    .N_SRC          (3),
    .IFG_CYCLES     (4),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (11)
  ) dut (
    .logic_clk      (clk),
    .logic_rst      (rst),
    .src_tdata_in   (src_tdata),
    .src_tvalid_in  (src_tvalid),
    .src_tready_out (src_tready),
    .src_tlast_in   (src_tlast),
    .net_tdata_out  (net_tdata),
    .net_tvalid_out (net_tvalid),
    .net_tready_in  (net_tready),
    .net_tlast_out  (net_tlast),
    .grant_out      (grant),
    .busy_out       (busy),
    .abort_out      (abort_o)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int abort_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] sb_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Output bundle: {tvalid, tdata, tlast, grant, src_tready, busy, abort}.
  function automatic logic [17:0] pack_out();
    return {net_tvalid, net_tdata, net_tlast, grant, src_tready, busy, abort_o};
  endfunction

  function automatic logic [17:0] mk(input logic ev, input logic [7:0] ed, input logic el,
                                     input logic [2:0] eg, input logic [2:0] etr,
                                     input logic eb, input logic ea);
    return {ev, ed, el, eg, etr, eb, ea};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int          tid;
    logic [2:0]  v;
    logic [2:0]  l;
    logic [23:0] d;
    logic        r;
    logic [17:0] e;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int tid, input logic [2:0] v, input logic [2:0] l,
                     input logic [23:0] d, input logic r, input logic [17:0] e);
    vec_t x;
    x.tid = tid; x.v = v; x.l = l; x.d = d; x.r = r; x.e = e;
    vq.push_back(x);
  endtask

  // Drive one vector just after a rising edge, compare at the falling edge.
  task automatic run_vec(input vec_t x, input int idx);
    tbl_v   = x.v;
    tbl_l   = x.l;
    tbl_d   = x.d;
    tbl_rdy = x.r;
    @(negedge clk);
    chk($sformatf("t%0d_v%0d", x.tid, idx), 32'(pack_out()), 32'(x.e));
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input int tid);
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].tid == tid) run_vec(vq[i], i);
    end
    tbl_v = '0; tbl_l = '0; tbl_d = '0; tbl_rdy = 1'b1;
  endtask

  task automatic do_reset();
    tbl_v = '0; tbl_l = '0; tbl_d = '0; tbl_rdy = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- source model ----------------
  logic [8:0] sbuf [3][16];
  int wr[3];
  int rd[3];

  always_comb begin
    mdl_v = '0;
    mdl_l = '0;
    mdl_d = '0;
    for (int i = 0; i < 3; i++) begin
      mdl_v[i]         = (rd[i] < wr[i]);
      mdl_l[i]         = mdl_v[i] ? sbuf[i][rd[i] % 16][8] : 1'b0;
      mdl_d[8*i +: 8]  = mdl_v[i] ? sbuf[i][rd[i] % 16][7:0] : 8'h00;
    end
  end

  always begin : src_model
    logic [2:0] hs;
    @(negedge clk);
    hs = model_en ? (src_tvalid & src_tready) : 3'b000;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (hs[i]) rd[i] = rd[i] + 1;
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (abort_o) abort_cnt++;
    if (mon_en && net_tvalid && net_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra_beat: got %h expected none", {net_tlast, net_tdata});
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_beat", 32'({net_tlast, net_tdata}), 32'(sb_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [7:0] bv;
    int fc;

    // Table 1: src1 alone sends 11..15, then 4 gap cycles and IDLE.
    add(1, 3'b010, 3'b000, {8'h00, 8'h11, 8'h00}, 1'b1, mk(0, 8'h00, 0, 3'b000, 3'b000, 0, 0));
    for (int b = 0; b < 5; b++) begin
      bv = 8'h11 + 8'(b);
      add(1, 3'b010, (b == 4) ? 3'b010 : 3'b000, {8'h00, bv, 8'h00}, 1'b1,
          mk(1, bv, (b == 4), 3'b010, 3'b010, 1, 0));
    end
    for (int g = 0; g < 4; g++)
      add(1, 3'b000, 3'b000, 24'h0, 1'b1, mk(0, 8'h00, 0, 3'b000, 3'b000, 1, 0));
    add(1, 3'b000, 3'b000, 24'h0, 1'b1, mk(0, 8'h00, 0, 3'b000, 3'b000, 0, 0));

    // Table 2: src0 frame A1 A2 A3 under toggling MAC ready.
    add(2, 3'b001, 3'b000, 24'h0000A1, 1'b1, mk(0, 8'h00, 0, 3'b000, 3'b000, 0, 0));
    add(2, 3'b001, 3'b000, 24'h0000A1, 1'b1, mk(1, 8'hA1, 0, 3'b001, 3'b001, 1, 0));
    add(2, 3'b001, 3'b000, 24'h0000A2, 1'b0, mk(1, 8'hA2, 0, 3'b001, 3'b000, 1, 0));
    add(2, 3'b001, 3'b000, 24'h0000A2, 1'b1, mk(1, 8'hA2, 0, 3'b001, 3'b001, 1, 0));
    add(2, 3'b001, 3'b001, 24'h0000A3, 1'b0, mk(1, 8'hA3, 1, 3'b001, 3'b000, 1, 0));
    add(2, 3'b001, 3'b001, 24'h0000A3, 1'b1, mk(1, 8'hA3, 1, 3'b001, 3'b001, 1, 0));
    add(2, 3'b000, 3'b000, 24'h000000, 1'b1, mk(0, 8'h00, 0, 3'b000, 3'b000, 1, 0));

    // Table 3: src2 stalls after 2 beats -> abort, drain, gap, then src0.
    add(3, 3'b100, 3'b000, 24'h210000, 1'b1, mk(0, 8'h00, 0, 3'b000, 3'b000, 0, 0));
    add(3, 3'b100, 3'b000, 24'h210000, 1'b1, mk(1, 8'h21, 0, 3'b100, 3'b100, 1, 0));
    add(3, 3'b100, 3'b000, 24'h220000, 1'b1, mk(1, 8'h22, 0, 3'b100, 3'b100, 1, 0));
    for (int s = 0; s < 8; s++)
      add(3, 3'b000, 3'b000, 24'h0, 1'b1, mk(0, 8'h00, 0, 3'b100, 3'b100, 1, 0));
    add(3, 3'b001, 3'b001, 24'h00000A, 1'b0, mk(1, 8'h00, 1, 3'b100, 3'b000, 1, 1));
    add(3, 3'b001, 3'b001, 24'h00000A, 1'b1, mk(1, 8'h00, 1, 3'b100, 3'b000, 1, 0));
    add(3, 3'b101, 3'b001, 24'h23000A, 1'b1, mk(0, 8'h00, 0, 3'b100, 3'b100, 1, 0));
    add(3, 3'b101, 3'b001, 24'h24000A, 1'b1, mk(0, 8'h00, 0, 3'b100, 3'b100, 1, 0));
    add(3, 3'b101, 3'b101, 24'h25000A, 1'b1, mk(0, 8'h00, 0, 3'b100, 3'b100, 1, 0));
    for (int g = 0; g < 4; g++)
      add(3, 3'b001, 3'b001, 24'h00000A, 1'b1, mk(0, 8'h00, 0, 3'b000, 3'b000, 1, 0));
    add(3, 3'b001, 3'b001, 24'h00000A, 1'b1, mk(0, 8'h00, 0, 3'b000, 3'b000, 0, 0));
    add(3, 3'b001, 3'b001, 24'h00000A, 1'b1, mk(1, 8'h0A, 1, 3'b001, 3'b001, 1, 0));

    // Table 4: first two beats of a src0 frame that gets reset mid-flight.
    add(4, 3'b001, 3'b000, 24'h0000B1, 1'b1, mk(0, 8'h00, 0, 3'b000, 3'b000, 0, 0));
    add(4, 3'b001, 3'b000, 24'h0000B1, 1'b1, mk(1, 8'hB1, 0, 3'b001, 3'b001, 1, 0));
    add(4, 3'b001, 3'b000, 24'h0000B2, 1'b1, mk(1, 8'hB2, 0, 3'b001, 3'b001, 1, 0));

    rst = 1'b1;
    tbl_v = '0; tbl_l = '0; tbl_d = '0; tbl_rdy = 1'b1;
    model_en = 1'b0;
    mon_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(pack_out()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_table(1);
    run_table(2);

    // Fairness: all three sources hold two 3-byte frames each.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 3; s++) begin
        for (int b = 0; b < 3; b++) begin
          bv = 8'(s * 16 + f * 4 + b);
          sbuf[s][wr[s]] = {(b == 2), bv};
          wr[s] = wr[s] + 1;
          exp_q.push_back({(b == 2), bv});
        end
      end
    end
    mon_en   = 1'b1;
    model_en = 1'b1;
    fc = 0;
    while (fc < 400 && (exp_q.size() != 0 || busy)) begin
      @(negedge clk);
      fc++;
    end
    chk("fair_all_beats_seen", 32'(exp_q.size()), 32'd0);
    chk("fair_idle_after", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    mon_en   = 1'b0;
    model_en = 1'b0;

    run_table(3);
    chk("abort_pulse_count", 32'(abort_cnt), 32'd1);

    wait_idle("idle_before_reset_test");
    run_table(4);

    // Third beat on the wire, then reset lands in the same cycle.
    tbl_v = 3'b011; tbl_l = 3'b000; tbl_d = 24'h00C1B3; tbl_rdy = 1'b1;
    #1;
    chk("beat3_before_reset", 32'({net_tvalid, net_tdata}), 32'({1'b1, 8'hB3}));
    rst = 1'b1;
    #1;
    chk("reset_midframe_outputs", 32'(pack_out()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("regrant_after_reset", 32'(pack_out()),
        32'(mk(1, 8'hB3, 0, 3'b001, 3'b001, 1, 0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
